truth_table_sweeper: RTL

//  Sequencer that exercises a 3-input, 1-output combinational logic block (e.g. the 0x84 gate) by

---
 rtl/truth_table_sweeper.sv | 96 +++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | truth_table_sweeper: steps a 3-input logic block through all 8 input       |
// | combinations, captures its response as a truth table, checks it. Rev 1.0   |
// +----------------------------------------------------------------------------+
module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED      = 8'h84
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic [2:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] combo;
  logic [7:0] cnt;
  logic [7:0] capture;
  logic [7:0] capture_next;
  logic       sample;

  // Combination i lands in bit [7-i] so the word reads like the gate's hex code.
  always_comb begin
    capture_next               = capture;
    capture_next[3'd7 - combo] = dut_out;
  end

  assign sample = (cnt == LAST_CNT);

  always_comb begin
    busy   = (state == ST_SETTLE);
    done   = (state == ST_DONE);
    dut_in = (state == ST_SETTLE) ? combo : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      combo     <= 3'd0;
      cnt       <= 8'd0;
      capture   <= 8'h00;
      table_out <= 8'h00;
      match     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state   <= ST_SETTLE;
            combo   <= 3'd0;
            cnt     <= 8'd0;
            capture <= 8'h00;
          end
        end
        ST_SETTLE: begin
          // Abort outranks the final sample, so an aborted sweep never reports.
          if (abort) begin
            state <= ST_IDLE;
          end else if (sample) begin
            capture <= capture_next;
            if (combo == 3'd7) begin
              state     <= ST_DONE;
              table_out <= capture_next;
              match     <= (capture_next == EXPECTED);
            end else begin
              combo <= combo + 3'd1;
              cnt   <= 8'd0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
